// File: rtl/seg_pkg.sv
// Shared seven-segment constants and FSM state type for the display driver and its scan decoder.
// Patterns are the 7 active-low segment bits {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_MINUS = 4'd11;
  localparam logic [3:0] CODE_BAD   = 4'd15;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment pattern to digit code translation; unknown patterns flag bad.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       bad
);

  always_comb begin
    code = CODE_BAD;
    bad  = 1'b0;
    case (pattern)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      SEG_MINUS: code = CODE_MINUS;
      default:   bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive receiver for the multiplexed 8-digit seven-segment bus: captures settled digits,
// assembles a frame, converts it to binary and offers it on a valid/ready port.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_sel,
  input  logic [7:0]  seg_led,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_bcd,
  output logic [26:0] out_value,
  output logic [3:0]  out_dp_pos,
  output logic        out_err,
  output logic        disp_off
);

  logic [7:0]  sel_q1, sel_q2, sel_q3;
  logic [7:0]  led_q1, led_q2, led_q3;
  logic [3:0]  settle_cnt;
  logic [15:0] idle_cnt;
  logic [15:0] tmo_cnt;
  state_t      state;
  logic [7:0]  mask;
  logic [26:0] acc;
  logic [2:0]  idx;

  logic [3:0]  code_mem [8];
  logic [7:0]  dp_mem;
  logic [7:0]  bad_mem;

  logic [7:0]  sel_n;
  logic        sel_onehot;
  logic        capture;
  logic        cap_we;
  logic [2:0]  dig_idx;
  logic [3:0]  dec_code;
  logic        dec_bad;
  logic [31:0] bcd_frame;
  logic [3:0]  dp_pos;
  logic        multi_dp;
  logic [3:0]  cur_code;
  logic [26:0] acc_next;

  seg_pattern_decode u_decode (
    .pattern (led_q2[6:0]),
    .code    (dec_code),
    .bad     (dec_bad)
  );

  assign sel_n      = ~sel_q2;
  assign sel_onehot = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
  assign capture    = (settle_cnt == 4'(SETTLE_CYC - 1)) && sel_onehot;
  assign cap_we     = capture && (state == COLLECT) && (mask != 8'hFF);

  always_comb begin
    dig_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_n[i]) dig_idx = 3'(i);
    end
  end

  // Scanning downward leaves the lowest lit dp as the reported position.
  always_comb begin
    dp_pos = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (dp_mem[i]) dp_pos = 4'(i + 1);
    end
  end
  assign multi_dp = (dp_mem & (dp_mem - 8'd1)) != 8'd0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bcd
    assign bcd_frame[4*gi +: 4] = code_mem[gi];
  end

  assign cur_code = code_mem[idx];
  assign acc_next = (acc << 3) + (acc << 1) + ((cur_code <= 4'd9) ? 27'(cur_code) : 27'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q1     <= 8'hFF;
      sel_q2     <= 8'hFF;
      sel_q3     <= 8'hFF;
      led_q1     <= 8'hFF;
      led_q2     <= 8'hFF;
      led_q3     <= 8'hFF;
      settle_cnt <= 4'd0;
      idle_cnt   <= 16'd0;
      disp_off   <= 1'b0;
    end else begin
      sel_q1 <= seg_sel;
      sel_q2 <= sel_q1;
      sel_q3 <= sel_q2;
      led_q1 <= seg_led;
      led_q2 <= led_q1;
      led_q3 <= led_q2;
      if ({sel_q2, led_q2} != {sel_q3, led_q3}) settle_cnt <= 4'd0;
      else if (settle_cnt != 4'd15)             settle_cnt <= settle_cnt + 4'd1;
      if (sel_q2 != 8'hFF)                         idle_cnt <= 16'd0;
      else if (idle_cnt != 16'(TIMEOUT_CYC))       idle_cnt <= idle_cnt + 16'd1;
      if (capture)                                 disp_off <= 1'b0;
      else if (sel_q2 == 8'hFF && idle_cnt == 16'(TIMEOUT_CYC - 1)) disp_off <= 1'b1;
    end
  end

  // Digit storage has no reset: the capture mask decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      code_mem[dig_idx] <= dec_code;
      dp_mem[dig_idx]   <= ~led_q2[7];
      bad_mem[dig_idx]  <= dec_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      mask       <= 8'd0;
      tmo_cnt    <= 16'd0;
      acc        <= 27'd0;
      idx        <= 3'd0;
      out_valid  <= 1'b0;
      out_bcd    <= 32'd0;
      out_value  <= 27'd0;
      out_dp_pos <= 4'd0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (mask == 8'hFF) begin
            state   <= CONVERT;
            mask    <= 8'd0;
            tmo_cnt <= 16'd0;
            acc     <= 27'd0;
            idx     <= 3'd7;
          end else if (cap_we) begin
            mask[dig_idx] <= 1'b1;
            tmo_cnt       <= 16'd0;
          end else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
            mask    <= 8'd0;
            tmo_cnt <= 16'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        CONVERT: begin
          acc <= acc_next;
          idx <= idx - 3'd1;
          if (idx == 3'd0) begin
            state      <= OUTPUT;
            out_valid  <= 1'b1;
            out_bcd    <= bcd_frame;
            out_value  <= acc_next;
            out_dp_pos <= dp_pos;
            out_err    <= (|bad_mem) || multi_dp;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed bench for seg_scan_decoder against a frame-level reference model.
module tb_seg_scan_decoder;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_sel;
  logic [7:0]  seg_led;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_bcd;
  logic [26:0] out_value;
  logic [3:0]  out_dp_pos;
  logic        out_err;
  logic        disp_off;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  cur_frame [8];
  logic [31:0] exp_bcd;
  logic [31:0] exp_value;
  logic [31:0] exp_dp;
  logic [31:0] exp_err;

  seg_scan_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .seg_sel    (seg_sel),
    .seg_led    (seg_led),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bcd    (out_bcd),
    .out_value  (out_value),
    .out_dp_pos (out_dp_pos),
    .out_err    (out_err),
    .disp_off   (disp_off)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Display glyphs for 0..9, blank (10) and minus (11).
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h7F; default: return 7'h3F;
    endcase
  endfunction

  function automatic int code_of(input logic [6:0] p);
    for (int d = 0; d < 12; d++) if (seg_of(d) == p) return d;
    return 15;
  endfunction

  task automatic model_frame();
    int ndp = 0;
    longint weight = 1;
    exp_bcd = 0; exp_value = 0; exp_dp = 0; exp_err = 0;
    for (int k = 0; k < 8; k++) begin
      int c = code_of(cur_frame[k][6:0]);
      exp_bcd[4*k +: 4] = 4'(c);
      if (c == 15) exp_err = 1;
      if (c <= 9) exp_value += 32'(c * weight);
      weight *= 10;
      if (!cur_frame[k][7]) begin
        ndp++;
        if (exp_dp == 0) exp_dp = 32'(k + 1);
      end
    end
    if (ndp > 1) exp_err = 1;
  endtask

  task automatic set_number(input int value);
    int v = value;
    for (int k = 0; k < 8; k++) begin
      cur_frame[k] = {1'b1, seg_of(v % 10)};
      v /= 10;
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 8; k++) begin
      int r = $urandom_range(0, 19);
      logic [6:0] p;
      if (r < 10)       p = seg_of(r);
      else if (r < 14)  p = seg_of(10);
      else if (r == 14) p = seg_of(11);
      else if (r == 15) begin
        p = 7'($urandom);
        if (code_of(p) != 15) p = 7'h55;
      end else p = seg_of(r - 10);
      cur_frame[k] = {($urandom_range(0, 5) != 0), p};
    end
  endtask

  task automatic scan(input int lo, input int hi, input int hold);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      seg_sel = 8'hFF ^ (8'h01 << k);
      seg_led = cur_frame[k];
      repeat (hold - 1) @(negedge clk);
    end
    @(negedge clk);
    seg_sel = 8'hFF;
    seg_led = 8'hFF;
  endtask

  task automatic wait_and_check(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s_valid", tag), 32'(out_valid), 1);
    if (out_valid) begin
      check($sformatf("%s_bcd", tag),   out_bcd,           exp_bcd);
      check($sformatf("%s_value", tag), 32'(out_value),    exp_value);
      check($sformatf("%s_dp", tag),    32'(out_dp_pos),   exp_dp);
      check($sformatf("%s_err", tag),   32'(out_err),      exp_err);
    end
  endtask

  task automatic accept(input string tag);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s_accept", tag), 32'(out_valid), 0);
  endtask

  initial begin
    logic stable;
    logic seen;
    rst = 1'b1;
    seg_sel = 8'hFF;
    seg_led = 8'hFF;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_bcd", out_bcd, 0);
    check("reset_value", 32'(out_value), 0);
    check("reset_dp", 32'(out_dp_pos), 0);
    check("reset_err", 32'(out_err), 0);
    check("reset_disp_off", 32'(disp_off), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    set_number(12345678);
    model_frame();
    scan(0, 7, 10);
    wait_and_check("n12345678");
    accept("n12345678");

    set_number(500);
    for (int k = 3; k < 8; k++) cur_frame[k] = {1'b1, seg_of(10)};
    cur_frame[1][7] = 1'b0;
    model_frame();
    scan(0, 7, 10);
    wait_and_check("n500");
    accept("n500");

    set_number(12345678);
    cur_frame[3] = 8'h55;
    model_frame();
    scan(0, 7, 10);
    wait_and_check("bad_d3");
    accept("bad_d3");

    for (int f = 0; f < 12; f++) begin
      rand_frame();
      model_frame();
      scan(0, 7, $urandom_range(6, 12));
      wait_and_check($sformatf("rand%0d", f));
      accept($sformatf("rand%0d", f));
    end

    seen = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      seg_sel = 8'hFF ^ (8'h01 << (i % 8));
      seg_led = {1'b1, seg_of(i % 10)};
      if (out_valid) seen = 1'b1;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    seg_sel = 8'hFF;
    seg_led = 8'hFF;
    repeat (20) @(negedge clk);
    check("glitch_no_valid", 32'(seen || out_valid), 0);

    rand_frame();
    model_frame();
    scan(5, 7, 8);
    repeat (20010) @(negedge clk);
    check("idle_disp_off", 32'(disp_off), 1);
    scan(0, 4, 8);
    repeat (30) @(negedge clk);
    check("timeout_discard", 32'(out_valid), 0);
    check("disp_off_clear", 32'(disp_off), 0);
    scan(5, 7, 8);
    wait_and_check("after_timeout");
    accept("after_timeout");

    set_number(24681357);
    model_frame();
    scan(0, 7, 10);
    wait_and_check("hold_a");
    set_number(97531);
    stable = 1'b1;
    fork
      scan(0, 7, 10);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!out_valid || out_bcd !== exp_bcd || 32'(out_value) !== exp_value) stable = 1'b0;
      end
    join
    check("hold_stable", 32'(stable), 1);
    accept("hold_a");
    repeat (30) @(negedge clk);
    check("no_leak", 32'(out_valid), 0);
    model_frame();
    scan(0, 7, 10);
    wait_and_check("hold_b");
    accept("hold_b");

    rand_frame();
    fork
      scan(0, 7, 10);
      begin
        int cyc = 0;
        while (dut.state != CONVERT && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
        check("reach_convert", 32'(dut.state == CONVERT), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_mask", 32'(dut.mask), 0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (30) @(negedge clk);
    check("rst_no_result", 32'(out_valid), 0);
    set_number(1);
    model_frame();
    scan(0, 7, 10);
    wait_and_check("after_rst");
    accept("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
